alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 53 +++++
 rtl/alu_issue_dec.sv | 81 ++++++++
 rtl/alu_issue.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: MIPS opcode/funct values, ALU Func
// encodings, the buffered op record and immediate-extension helpers.
package alu_issue_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_LUI  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;

    typedef struct packed {
        logic [3:0]        func;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [4:0]        dst;
        logic              ill;
    } alu_op_t;

    function automatic logic signed [DATA_W-1:0] sext16(input logic signed [15:0] imm);
        return DATA_W'(imm);
    endfunction

    function automatic logic [DATA_W-1:0] zext16(input logic [15:0] imm);
        return {{(DATA_W-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational MIPS-word to ALU-op decoder; unsupported encodings collapse to
// an inert add of zeros with no destination and raise illegal.
module alu_issue_dec
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [3:0]  func,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [4:0]  dst,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        unused_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    // rs field and shamt are not needed: operands arrive already read from the register file
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        func    = ALU_ADD;
        in1     = rs_val;
        in2     = sext16(imm);
        dst     = instr[20:16];
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                in2 = rt_val;
                dst = instr[15:11];
                case (funct)
                    FN_ADD, FN_ADDU: func = ALU_ADD;
                    FN_SUB, FN_SUBU: func = ALU_SUB;
                    FN_AND:          func = ALU_AND;
                    FN_OR:           func = ALU_OR;
                    FN_XOR:          func = ALU_XOR;
                    FN_SLT:          func = ALU_SLT;
                    default:         illegal = 1'b1;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                func = ALU_SUB;
                in2  = rt_val;
                dst  = '0;
            end
            OP_ADDI, OP_ADDIU, OP_LW: func = ALU_ADD;
            OP_SW: dst = '0;
            OP_SLTI: func = ALU_SLT;
            OP_ANDI: begin
                func = ALU_AND;
                in2  = zext16(imm);
            end
            OP_ORI: begin
                func = ALU_OR;
                in2  = zext16(imm);
            end
            OP_XORI: begin
                func = ALU_XOR;
                in2  = zext16(imm);
            end
            OP_LUI: begin
                func = ALU_LUI;
                in2  = zext16(imm);
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            func = ALU_ADD;
            in1  = '0;
            in2  = '0;
            dst  = '0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode then a 2-entry skid buffer (output reg + skid reg).
// Define ALU_ISSUE_ILLEGAL_EN to expose out_illegal for unsupported encodings.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_func,
    output logic [31:0] out_in1,
    output logic [31:0] out_in2,
    output logic [4:0]  out_dst
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic        out_illegal
`endif
);

    alu_op_t dec_p0;
    alu_op_t op_p1;
    alu_op_t sk_op_p1;
    logic    vld_p1;
    logic    sk_vld_p1;
    logic    acc_p0;
    logic    ld_p1;

    alu_issue_dec u_dec (
        .instr   (in_instr),
        .rs_val  (in_rs_val),
        .rt_val  (in_rt_val),
        .func    (dec_p0.func),
        .in1     (dec_p0.in1),
        .in2     (dec_p0.in2),
        .dst     (dec_p0.dst),
        .illegal (dec_p0.ill)
    );

    // ready depends only on the skid flop, so no input reaches in_ready combinationally
    assign in_ready = ~sk_vld_p1;
    assign acc_p0   = in_valid & in_ready;
    assign ld_p1    = ~vld_p1 | out_ready;

    // ---- p0 -> p1: output register and skid register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            sk_vld_p1 <= 1'b0;
            op_p1     <= '0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            sk_vld_p1 <= 1'b0;
        end else if (ld_p1) begin
            if (sk_vld_p1) begin
                op_p1     <= sk_op_p1;
                vld_p1    <= 1'b1;
                sk_vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= acc_p0;
                if (acc_p0) begin
                    op_p1 <= dec_p0;
                end
            end
        end else if (acc_p0) begin
            sk_vld_p1 <= 1'b1;
        end
    end

    // skid payload is qualified by sk_vld_p1, so it needs no reset
    always_ff @(posedge clk) begin
        if (!flush && !ld_p1 && acc_p0) begin
            sk_op_p1 <= dec_p0;
        end
    end

    assign out_valid = vld_p1;
    assign out_func  = op_p1.func;
    assign out_in1   = op_p1.in1;
    assign out_in2   = op_p1.in2;
    assign out_dst   = op_p1.dst;

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign out_illegal = op_p1.ill;
`else
    logic unused_ill;
    assign unused_ill = op_p1.ill;
`endif

endmodule
